// File: rtl/bcd_pkg.sv
// Shared BCD arithmetic definitions: digit type, digit constants and the
// control states of the digit-serial BCD subtractor.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX   = 4'd9;
  localparam bcd_digit_t BCD_RADIX = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    COMP = 2'd3
  } bcd_sub_state_e;

endpackage

// File: rtl/bcd_serial_sub_if.sv
// Handshake and operand/result bundle of the digit-serial BCD subtractor.
// Carries the extra 'negative' flag when BCD_SUB_SIGN_MAG_EN is defined.
interface bcd_serial_sub_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
);
  logic                          start;
  logic [BCD_DIGIT_W*DIGITS-1:0] a;
  logic [BCD_DIGIT_W*DIGITS-1:0] b;
  logic                          borrow_in;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] diff;
  logic                          borrow_out;
  logic                          invalid;
`ifdef BCD_SUB_SIGN_MAG_EN
  logic                          negative;

  modport master (output start, a, b, borrow_in,
                  input  busy, done, diff, borrow_out, invalid, negative);
  modport slave  (input  start, a, b, borrow_in,
                  output busy, done, diff, borrow_out, invalid, negative);
`else
  modport master (output start, a, b, borrow_in,
                  input  busy, done, diff, borrow_out, invalid);
  modport slave  (input  start, a, b, borrow_in,
                  output busy, done, diff, borrow_out, invalid);
`endif

endinterface

// File: rtl/bcd_digit_sub.sv
// Combinational single BCD digit subtract: d = x - y - bin with decimal borrow.
// A non-BCD input digit (>9) is treated as 0 and flagged on 'bad'.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout,
  output logic       bad
);

  logic                 x_bad;
  logic                 y_bad;
  bcd_digit_t           x_eff;
  bcd_digit_t           y_eff;
  logic [BCD_DIGIT_W:0] t;

  // NOTE: every output gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    x_bad = (x > BCD_MAX);
    y_bad = (y > BCD_MAX);
    x_eff = x_bad ? '0 : x;
    y_eff = y_bad ? '0 : y;
    t     = {1'b0, x_eff} - {1'b0, y_eff} - {{BCD_DIGIT_W{1'b0}}, bin};
    bout  = t[BCD_DIGIT_W];
    // t is in -10..9; adding 10 in 4-bit arithmetic lands the negative case on 0..9.
    d     = bout ? (t[BCD_DIGIT_W-1:0] + BCD_RADIX) : t[BCD_DIGIT_W-1:0];
    bad   = x_bad | y_bad;
  end

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial multi-digit BCD subtractor, diff = a - b - borrow_in, LSD first.
// Define BCD_SUB_SIGN_MAG_EN to convert negative results to sign/magnitude.
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  bcd_serial_sub_if.slave   bus
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  bcd_sub_state_e   state_q;
  bcd_sub_state_e   state_d;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     diff_q;
  logic             borrow_q;
  logic             borrow_out_q;
  logic             invalid_q;
  logic [IDX_W-1:0] idx_q;
  logic             last;

  bcd_digit_t       sub_x;
  bcd_digit_t       sub_y;
  bcd_digit_t       sub_d;
  logic             sub_bout;
  logic             sub_bad;

`ifdef BCD_SUB_SIGN_MAG_EN
  logic             negative_q;
`endif

  assign last = (idx_q == LAST_IDX);

  // One digit slice feeds both the subtract pass and the complement pass.
  always_comb begin
    sub_x = a_q[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W];
    sub_y = b_q[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W];
`ifdef BCD_SUB_SIGN_MAG_EN
    if (state_q == COMP) begin
      sub_x = '0;
      sub_y = diff_q[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W];
    end
`endif
  end

  bcd_digit_sub u_digit (
    .x    (sub_x),
    .y    (sub_y),
    .bin  (borrow_q),
    .d    (sub_d),
    .bout (sub_bout),
    .bad  (sub_bad)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        if (last) begin
`ifdef BCD_SUB_SIGN_MAG_EN
          state_d = sub_bout ? COMP : DONE;
`else
          state_d = DONE;
`endif
        end
      end
      COMP:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand registers are reset along with the outputs so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      invalid_q    <= 1'b0;
      idx_q        <= '0;
`ifdef BCD_SUB_SIGN_MAG_EN
      negative_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            borrow_q  <= bus.borrow_in;
            diff_q    <= '0;
            invalid_q <= 1'b0;
            idx_q     <= '0;
          end
        end
        RUN: begin
          diff_q[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W] <= sub_d;
          invalid_q <= invalid_q | sub_bad;
          if (last) begin
            // The complement pass starts from a clear borrow.
            borrow_q     <= 1'b0;
            borrow_out_q <= sub_bout;
            idx_q        <= '0;
`ifdef BCD_SUB_SIGN_MAG_EN
            negative_q   <= sub_bout;
`endif
          end else begin
            borrow_q <= sub_bout;
            idx_q    <= idx_q + 1'b1;
          end
        end
        COMP: begin
          diff_q[BCD_DIGIT_W*idx_q +: BCD_DIGIT_W] <= sub_d;
          borrow_q <= sub_bout;
          idx_q    <= last ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state_q == RUN) || (state_q == COMP);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.invalid    = invalid_q;
`ifdef BCD_SUB_SIGN_MAG_EN
  assign bus.negative   = negative_q;
`endif

endmodule
